// File: rtl/user_module_frame_tx_pkg.sv
// Shared types and constants for the bit-serial frame transmitter.
// Optional parity stage is controlled by USER_MODULE_FRAME_TX_PARITY_EN.
package user_module_frame_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Total cycles a frame keeps busy high: start + data [+ parity] + stop bits.
    function automatic int unsigned frame_len(input int unsigned clks_per_bit,
                                              input int unsigned data_bits,
                                              input bit          parity_en);
        return (2 + data_bits + (parity_en ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/frame_tx_bit_timer.sv
// Per-bit divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module frame_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic bit_end_o
);

    logic [3:0] cnt_q, cnt_d;

    assign bit_end_o = (cnt_q == 4'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + 4'd1;
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/user_module_frame_tx.sv
// Tiny Tapeout frame transmitter: start bit, data LSB-first, optional even parity
// (USER_MODULE_FRAME_TX_PARITY_EN), stop bit on io_out[0].
module user_module_frame_tx
    import user_module_frame_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_BITS    = 5
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 15) begin : g_bad_clks_per_bit
        $error("CLKS_PER_BIT must be in 1..15");
    end
    if (DATA_BITS < 1 || DATA_BITS > 5) begin : g_bad_data_bits
        $error("DATA_BITS must be in 1..5");
    end

    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    logic clk;
    logic rst_n;
    logic send;
    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign send  = io_in[2];

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 txd;
    logic                 busy;
`ifdef USER_MODULE_FRAME_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Divider is held at zero while idle so START always gets a full bit period.
    frame_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (state_q == StIdle),
        .bit_end_o(bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (send) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && bit_cnt_q == LastBit) begin
`ifdef USER_MODULE_FRAME_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef USER_MODULE_FRAME_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        txd = IDLE_LEVEL;
        case (state_q)
            StStart:  txd = START_LEVEL;
            StData:   txd = shift_q[0];
`ifdef USER_MODULE_FRAME_TX_PARITY_EN
            StParity: txd = parity_q;
`endif
            default:  txd = IDLE_LEVEL;
        endcase
        busy   = (state_q != StIdle);
        io_out = {2'b00, state_q, done_q, busy, txd};
    end

    // Datapath: capture on the accepted send, shift at each data bit end.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
`ifdef USER_MODULE_FRAME_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (send) begin
                    shift_d   = io_in[3 +: DATA_BITS];
                    bit_cnt_d = '0;
`ifdef USER_MODULE_FRAME_TX_PARITY_EN
                    parity_d  = ^io_in[3 +: DATA_BITS];
`endif
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            StStop:  done_d = bit_end;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
`ifdef USER_MODULE_FRAME_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
`ifdef USER_MODULE_FRAME_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_user_module_frame_tx.sv
// Self-checking bench for user_module_frame_tx: table of frames plus directed
// sequences for reset, held send and mid-frame abort.
module tb_user_module_frame_tx;
    import user_module_frame_tx_pkg::*;

    localparam int unsigned CPB = 4;
    localparam int unsigned DB  = 5;
`ifdef USER_MODULE_FRAME_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int unsigned FL = frame_len(CPB, DB, PAR);

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       send  = 1'b0;
    logic [4:0] data  = 5'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {data, send, rst_n, clk};

    user_module_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    // seq lists data bits in transmit order (seq[4] goes out first).
    typedef struct {
        logic [4:0] data;
        logic [4:0] seq;
        logic       par;
        logic       chg;
        logic [4:0] alt;
    } vec_t;

    vec_t vecs[6];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_level(input int unsigned i, input logic [4:0] seq,
                                       input logic par);
        int unsigned slot;
        slot = i / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DB) return seq[DB - slot];
        if (PAR && slot == DB + 1) return par;
        return 1'b1;
    endfunction

    function automatic logic [2:0] exp_state(input int unsigned i);
        int unsigned slot;
        slot = i / CPB;
        if (slot == 0) return 3'd1;
        if (slot <= DB) return 3'd2;
        if (PAR && slot == DB + 1) return 3'd3;
        return 3'd4;
    endfunction

    task automatic run_frame(input string name, input vec_t v);
        logic [31:0] cap;
        logic [31:0] expv;
        int          busy_n;
        int          done_bad;
        int          st_bad;
        cap      = '0;
        expv     = '0;
        busy_n   = 0;
        done_bad = 0;
        st_bad   = 0;
        data = v.data;
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int i = 0; i < int'(FL); i++) begin
            cap[i]  = io_out[0];
            expv[i] = exp_level(i, v.seq, v.par);
            busy_n += int'(io_out[1]);
            done_bad += int'(io_out[2]);
            if (io_out[5:3] !== exp_state(i)) st_bad++;
            if (v.chg && i == 9) data = v.alt;
            tick();
        end
        check({name, "_txd"}, cap, expv);
        check({name, "_busy_cycles"}, busy_n, FL);
        check({name, "_done_early"}, done_bad, 0);
        check({name, "_states"}, st_bad, 0);
        check({name, "_end_out"}, io_out, 8'h05);
        tick();
        check({name, "_done_clear"}, io_out, 8'h01);
    endtask

    initial begin
        int bad;
        int dones;
        int bb;
        int db;
        int tb_;

        vecs[0] = '{data: 5'b10110, seq: 5'b01101, par: 1'b1, chg: 1'b0, alt: 5'b00000};
        vecs[1] = '{data: 5'b00001, seq: 5'b10000, par: 1'b1, chg: 1'b1, alt: 5'b11110};
        vecs[2] = '{data: 5'b11111, seq: 5'b11111, par: 1'b1, chg: 1'b0, alt: 5'b00000};
        vecs[3] = '{data: 5'b00000, seq: 5'b00000, par: 1'b0, chg: 1'b1, alt: 5'b11111};
        vecs[4] = '{data: 5'b01011, seq: 5'b11010, par: 1'b1, chg: 1'b0, alt: 5'b00000};
        vecs[5] = '{data: 5'b10010, seq: 5'b01001, par: 1'b0, chg: 1'b0, alt: 5'b00000};

        // Reset then idle window.
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_state", io_out, 8'h01);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (io_out !== 8'h01) bad++;
        end
        check("idle_window", bad, 0);

        for (int k = 0; k < 6; k++) begin
            run_frame($sformatf("frame%0d", k), vecs[k]);
        end

        // Held send: back-to-back frames with a single idle cycle between.
        data = 5'b10110;
        send = 1'b1;
        tick();
        bb    = 0;
        db    = 0;
        tb_   = 0;
        dones = 0;
        for (int c = 0; c < 100; c++) begin
            int  pos;
            logic et;
            pos = c % int'(FL + 1);
            et  = (pos < int'(FL)) ? exp_level(pos, 5'b01101, 1'b1) : 1'b1;
            if (io_out[1] !== (pos < int'(FL))) bb++;
            if (io_out[2] !== (pos == int'(FL))) db++;
            if (io_out[0] !== et) tb_++;
            dones += int'(io_out[2] === 1'b1);
            tick();
        end
        send = 1'b0;
        check("held_busy", bb, 0);
        check("held_done", db, 0);
        check("held_txd", tb_, 0);
        check("held_done_count", dones, 100 / (FL + 1));
        for (int k = 0; k < 40 && io_out[1] === 1'b1; k++) tick();
        check("held_drain", io_out[1], 1'b0);
        tick();
        check("held_quiet", io_out, 8'h01);

        // Asynchronous abort during data bit 3 (slot 4, data bit value 0).
        data = 5'b10110;
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (17) tick();
        check("pre_abort_out", io_out[5:0], 6'b010010);
        #3 rst_n = 1'b0;
        #1;
        check("abort_async", io_out, 8'h01);
        #2 rst_n = 1'b1;
        tick();
        check("abort_idle", io_out, 8'h01);
        run_frame("post_abort", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
